// File: rtl/ipm_distributed_sync_fifo_v1_3.sv
// Single-clock FIFO on distributed RAM with STD (optionally double-registered) or FWFT read,
// exact water level, synchronous flush and one-cycle overflow/underflow pulses.
module ipm_distributed_sync_fifo_v1_3 #(
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter string       READ_MODE        = "STD",
  parameter int unsigned OUT_REG          = 0,
  parameter int unsigned ALMOST_FULL_NUM  = 4,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   water_level
);

  localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned         LW       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = LW'(DEPTH - ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = LW'(ALMOST_EMPTY_NUM);
  localparam bit                  IS_FWFT  = (READ_MODE == "FWFT");

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // Accept decisions use the registered flags; flush masks both sides.
  assign w_wr_ok = wr_en & ~r_full & ~flush;
  assign w_rd_ok = rd_en & ~r_empty & ~flush;

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else if (w_wr_ok & ~w_rd_ok) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_rd_ok & ~w_wr_ok) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == FULL_LVL);
      r_afull  <= (w_level_nxt >= AF_LVL);
      r_empty  <= (w_level_nxt == '0);
      r_aempty <= (w_level_nxt <= AE_LVL);
      r_ovf    <= wr_en & r_full & ~flush;
      r_udf    <= rd_en & r_empty & ~flush;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // RAM has no reset so it maps onto distributed memory.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign water_level  = r_level;

  if (IS_FWFT) begin : g_fwft
    // Head word read asynchronously; forced to zero while empty so reset shows zero.
    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_data  <= '0;
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_rd_ok;
        if (w_rd_ok) r_s1_data <= r_mem[r_rd_ptr];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_s2_data;
      logic                  r_s2_valid;

      // Flush drops a word still in flight between the two stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid & ~flush;
          if (r_s1_valid & ~flush) r_s2_data <= r_s1_data;
        end
      end

      assign rd_data  = r_s2_data;
      assign rd_valid = r_s2_valid;
    end else begin : g_noreg
      assign rd_data  = r_s1_data;
      assign rd_valid = r_s1_valid;
    end
  end

endmodule

// File: tb/tb_ipm_distributed_sync_fifo_v1_3.sv
// Drives STD, STD+OUT_REG and FWFT instances (depth 16, 8-bit) with one stimulus stream and
// checks all of them against a queue-based model every cycle, plus directed literal checks.
module tb_ipm_distributed_sync_fifo_v1_3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [2:0] full_w, afull_w, ovf_w, empty_w, aempty_w, udf_w, rv_w;
  logic [7:0] rd_w  [3];
  logic [4:0] lvl_w [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ipm_distributed_sync_fifo_v1_3 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_MODE("STD"), .OUT_REG(0),
    .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(full_w[0]), .almost_full(afull_w[0]), .overflow(ovf_w[0]), .rd_en(rd_en),
    .rd_data(rd_w[0]), .rd_valid(rv_w[0]), .empty(empty_w[0]), .almost_empty(aempty_w[0]),
    .underflow(udf_w[0]), .water_level(lvl_w[0])
  );

  ipm_distributed_sync_fifo_v1_3 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_MODE("STD"), .OUT_REG(1),
    .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
  ) u_oreg (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(full_w[1]), .almost_full(afull_w[1]), .overflow(ovf_w[1]), .rd_en(rd_en),
    .rd_data(rd_w[1]), .rd_valid(rv_w[1]), .empty(empty_w[1]), .almost_empty(aempty_w[1]),
    .underflow(udf_w[1]), .water_level(lvl_w[1])
  );

  ipm_distributed_sync_fifo_v1_3 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_MODE("FWFT"), .OUT_REG(0),
    .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(full_w[2]), .almost_full(afull_w[2]), .overflow(ovf_w[2]), .rd_en(rd_en),
    .rd_data(rd_w[2]), .rd_valid(rv_w[2]), .empty(empty_w[2]), .almost_empty(aempty_w[2]),
    .underflow(udf_w[2]), .water_level(lvl_w[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: contents as a queue, read results as a 1- and 2-cycle delay line.
  logic [7:0] q[$];
  logic       e_ovf = 1'b0, e_udf = 1'b0;
  logic       s1v = 1'b0, s2v = 1'b0;
  logic [7:0] s1d = 8'h00, h0 = 8'h00, h1 = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      e_ovf = 1'b0; e_udf = 1'b0;
      s1v = 1'b0; s2v = 1'b0;
      h0 = 8'h00; h1 = 8'h00;
    end else begin
      int         n;
      logic       rv;
      logic [7:0] rdd;
      n     = q.size();
      e_ovf = !flush && wr_en && n == 16;
      e_udf = !flush && rd_en && n == 0;
      rv    = 1'b0;
      rdd   = 8'h00;
      if (flush) begin
        q.delete();
      end else begin
        if (rd_en && n > 0) begin
          rv  = 1'b1;
          rdd = q.pop_front();
        end
        if (wr_en && n < 16) q.push_back(wr_data);
      end
      s2v = s1v && !flush;
      if (s1v && !flush) h1 = s1d;
      s1v = rv;
      if (rv) begin
        s1d = rdd;
        h0  = rdd;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("level%0d", k), lvl_w[k], n);
      chk($sformatf("empty%0d", k), empty_w[k], n == 0);
      chk($sformatf("full%0d", k), full_w[k], n == 16);
      chk($sformatf("afull%0d", k), afull_w[k], n >= 12);
      chk($sformatf("aempty%0d", k), aempty_w[k], n <= 4);
      chk($sformatf("ovf%0d", k), ovf_w[k], e_ovf);
      chk($sformatf("udf%0d", k), udf_w[k], e_udf);
    end
    chk("std_valid", rv_w[0], s1v);
    chk("std_data", rd_w[0], h0);
    chk("oreg_valid", rv_w[1], s2v);
    chk("oreg_data", rd_w[1], h1);
    chk("fwft_valid", rv_w[2], n > 0);
    if (n > 0) chk("fwft_data", rd_w[2], q[0]);
  end

  // Inputs applied now are sampled by the next rising edge; returns just after that edge.
  task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_level", lvl_w[k], 0);
      chk("rst_empty", empty_w[k], 1);
      chk("rst_aempty", aempty_w[k], 1);
      chk("rst_full", full_w[k], 0);
      chk("rst_valid", rv_w[k], 0);
      chk("rst_data", rd_w[k], 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 3)  chk("aempty_at4", aempty_w[0], 1);
      if (i == 4)  chk("aempty_at5", aempty_w[0], 0);
      if (i == 10) chk("afull_at11", afull_w[0], 0);
      if (i == 11) chk("afull_at12", afull_w[0], 1);
    end
    chk("fill_full", full_w[0], 1);
    chk("fill_level", lvl_w[0], 16);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_pulse", ovf_w[0], 1);
      chk("ovf_level", lvl_w[0], 16);
    end

    // Drain: STD one cycle, OUT_REG two cycles, FWFT shows the next head
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", rv_w[0], 1);
      chk("drain_data", rd_w[0], i);
      if (i > 0) begin
        chk("drain_oreg_valid", rv_w[1], 1);
        chk("drain_oreg_data", rd_w[1], i - 1);
      end
      if (i < 15) chk("drain_fwft_head", rd_w[2], i + 1);
    end
    chk("drain_empty", empty_w[0], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", rv_w[0], 0);
    chk("oreg_last_data", rd_w[1], 8'h0F);

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_pulse", udf_w[0], 1);
    chk("udf_valid", rv_w[0], 0);

    drive(1'b1, 8'h33, 1'b1, 1'b0);
    chk("simul0_udf", udf_w[0], 1);
    chk("simul0_level", lvl_w[0], 1);

    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
      chk("simul5_level", lvl_w[0], 5);
    end

    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_flush_level", lvl_w[0], 9);
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("flush_level", lvl_w[0], 0);
    chk("flush_empty", empty_w[0], 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_flush_level", lvl_w[1], 0);

    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft_a5_empty", empty_w[2], 0);
    chk("fwft_a5_data", rd_w[2], 8'hA5);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_5a_data", rd_w[2], 8'h5A);
    chk("fwft_5a_valid", rv_w[2], 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_drained", empty_w[2], 1);

    // Async reset in the middle of a write burst
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_level", lvl_w[k], 0);
      chk("arst_empty", empty_w[k], 1);
      chk("arst_full", full_w[k], 0);
      chk("arst_valid", rv_w[k], 0);
      chk("arst_data", rd_w[k], 0);
      chk("arst_ovf", ovf_w[k], 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    for (int blk = 0; blk < 10; blk++) begin
      int pw, pr;
      pw = $urandom_range(85, 15);
      pr = $urandom_range(85, 15);
      for (int c = 0; c < 200; c++) begin
        drive($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
              $urandom_range(63) == 0);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipm_distributed_sync_fifo_v1_3.md
Name: ipm_distributed_sync_fifo_v1_3

Overview:
- Single-clock FIFO built on distributed RAM, for intra-domain buffering such as FFT-to-display line staging where no clock crossing is needed.
- Parametrised in width, depth and read mode: standard registered read, optional extra output register, or first-word-fall-through (FWFT).
- Adds an exact water level, a synchronous flush, and one-cycle overflow/underflow error pulses.
- Full/empty/almost flags are registered.

Parameters:
- ADDR_WIDTH, 10: depth = 2^ADDR_WIDTH words; legal range 4..10.
- DATA_WIDTH, 32: word width; legal range 1..256.
- READ_MODE, "STD": "STD" (registered read) or "FWFT" (head word always presented).
- OUT_REG, 0: 0 or 1; adds one output register in STD mode; must be 0 in FWFT mode.
- ALMOST_FULL_NUM, 4: almost_full asserts when level >= 2^ADDR_WIDTH - ALMOST_FULL_NUM; legal range 1..2^ADDR_WIDTH-1.
- ALMOST_EMPTY_NUM, 4: almost_empty asserts when level <= ALMOST_EMPTY_NUM; legal range 1..2^ADDR_WIDTH-1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear of FIFO contents.
- wr_data, input, DATA_WIDTH: write data.
- wr_en, input, 1: write request.
- full, output, 1: level == 2^ADDR_WIDTH.
- almost_full, output, 1: almost-full flag.
- overflow, output, 1: pulse, write attempted while full.
- rd_en, input, 1: read request (pop in FWFT mode).
- rd_data, output, DATA_WIDTH: read data.
- rd_valid, output, 1: rd_data holds a newly read word (STD mode); equals ~empty in FWFT mode.
- empty, output, 1: level == 0.
- almost_empty, output, 1: almost-empty flag.
- underflow, output, 1: pulse, read attempted while empty.
- water_level, output, ADDR_WIDTH+1: current word count, 0..2^ADDR_WIDTH.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, water_level=0, overflow=0, underflow=0, rd_valid=0, rd_data=0. Output regs clear immediately; RAM contents undefined.
- Accept rules: wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty. Both use registered flags from the current cycle.
  - Write while full is dropped, even with a simultaneous read.
  - Read while empty is dropped, even with a simultaneous write.
- Pointers: ADDR_WIDTH bits, natural wrap 2^ADDR_WIDTH-1 -> 0. wr_ok writes mem[wr_ptr] and increments wr_ptr; rd_ok increments rd_ptr.
- Level next-state: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Flags: all computed from level next-state and registered, so they are exact in the cycle after the access. water_level is registered, equal to the level.
- overflow <= wr_en & full; underflow <= rd_en & empty. Each is a one-cycle pulse per offending cycle, not sticky.
- STD mode:
  - OUT_REG=0: on rd_ok, rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle.
  - OUT_REG=1: one extra stage, so rd_data and rd_valid arrive 2 cycles after rd_ok.
  - rd_valid is 0 in every cycle without a completed read. rd_data holds its last value.
- FWFT mode:
  - rd_data = mem[rd_ptr] (asynchronous distributed-RAM read). It is valid whenever empty=0.
  - rd_en pops the word; the next word appears in the same cycle that rd_ptr updates.
  - First-write latency: a word written at edge N is visible, with empty=0, after edge N+1.
- Write-to-read: a word written at edge N is readable (rd_ok possible) from edge N+1 onward. There is no same-cycle bypass.
- Flush (synchronous, rst has priority):
  - Sets pointers, level and water_level to 0; empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, including any in-flight OUT_REG stage.
  - wr_en and rd_en in the flush cycle are ignored; overflow and underflow are not raised.
- Reset mid-operation: all state returns to reset values asynchronously. Operation resumes on the first edge after rst deasserts.

Test Plan:
- Fill/drain, depth 16, DATA_WIDTH=8, STD, OUT_REG=0:
  - Write 0x00..0x0F -> full=1 and water_level=16 after the 16th write edge; almost_full=1 from level 12.
  - Read 16 words -> rd_data 0x00..0x0F, each with rd_valid one cycle after rd_en; empty=1 and almost_empty=1 at level 4 and below.
- Boundary errors:
  - wr_en held 3 cycles while full, rd_en=0 -> 3 overflow pulses; level stays 16; no data corrupted.
  - rd_en while empty -> underflow pulse; rd_valid=0.
- Simultaneous access:
  - At level 5, wr_en=rd_en=1 for 10 cycles -> level stays 5; ordering is preserved.
  - At level 0, wr_en=rd_en=1 -> write accepted, read dropped, underflow=1, level 1.
- FWFT:
  - Write 0xA5 at edge N -> empty=0 and rd_data=0xA5 after edge N+1.
  - rd_en pops it; a second word 0x5A is then presented the same cycle.
- OUT_REG=1: rd_en accepted at edge N -> rd_valid=1 and correct data after edge N+2. Pointer wrap exercised over 40 words.
- Flush and reset: flush at level 9 with wr_en=1 -> level 0, empty=1, no write stored. Async rst pulse mid-burst -> all outputs at reset values before the next clk edge.
